dmem_lsu_ctrl: RTL
==================

# dmem_lsu_ctrl

Load/store sequencer between the core's memory stage and the word-only data memory, which has a combinational read and a write on the clock edge when write_en is high and read_en is low.
- Accepts one byte, halfword or word request at a time over a valid/ready handshake.
- Byte and halfword stores are a read-modify-write: read the word, merge, then a separate write cycle.
- Returns sign- or zero-extended load data and an error flag for bad accesses.

## Interface
- MEM_WORDS, 128, number of 32-bit words in the attached memory; used for the range check.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller idle and able to accept.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I width code:
  - 000 LB/SB, 001 LH/SH, 010 LW/SW
  - 100 LBU, 101 LHU
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low byte or halfword is used for SB/SH.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  qualified by rsp_valid; misaligned, out-of-range or illegal funct3.
- mem_read_en  output  1  to memory read_en.
- mem_write_en  output  1  to memory write_en; never high together with mem_read_en.
- mem_address  output  32  to memory address; always {word_index, 2'b00}.
- mem_wdata  output  32  to memory data_in.
- mem_rdata  input  32  from memory data_out; combinational, valid in the same cycle as mem_read_en.

## Operation
States: IDLE, LOAD, RMW_RD, WRITE, RESP.

- **IDLE**
  - req_ready=1.
  - On req_valid: latch we, funct3, addr and wdata.
  - Next state:
    - Error → RESP with err=1.
    - Load → LOAD.
    - SW → WRITE, with the buffer set to wdata.
    - SB/SH → RMW_RD.
- **LOAD**
  - mem_read_en=1.
  - Select the lane: byte uses addr[1:0]; halfword uses addr[1].
  - Extend the lane (sign for LB/LH, zero for LBU/LHU) and register it into rsp_rdata.
  - → RESP.
- **RMW_RD**
  - mem_read_en=1.
  - Buffer = mem_rdata with the addressed byte or halfword lane replaced by wdata[7:0] or wdata[15:0].
  - → WRITE.
- **WRITE**
  - mem_write_en=1, mem_read_en=0, mem_wdata=buffer.
  - → RESP.
- **RESP**
  - rsp_valid=1 for exactly one cycle.
  - → IDLE.
  - There is no response backpressure; the consumer must take the pulse.
- Lanes are little-endian: byte k occupies bits [8k+7:8k].
- Error rules (only with the macro enabled):
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - addr[31:2] ≥ MEM_WORDS.
  - funct3 ∈ {011, 110, 111}, or funct3 ∈ {100, 101} with req_we=1.
  - An errored request issues no memory access.

## Timing
- Acceptance cycle = the cycle where req_valid && req_ready.
- rsp_valid latency after acceptance:
  - error: 1 cycle
  - load and SW: 2 cycles
  - SB/SH: 3 cycles
- req_ready=0 from the cycle after acceptance through the RESP cycle.
- Back-to-back requests: the next can be accepted in the cycle after RESP.
- Request inputs are ignored while not in IDLE.
- Reset values: state IDLE, req_ready=1 after reset deasserts, and the following are all 0:
  - rsp_valid, rsp_rdata, rsp_err
  - mem_read_en, mem_write_en, mem_address, mem_wdata
- Reset has priority over every transition, including the IDLE acceptance.
- mem_write_en and mem_read_en are forced to 0 combinationally while reset=1. A reset asserted during WRITE therefore aborts the write, leaving memory unchanged.
- Reset during LOAD or RMW_RD discards the request; no response is produced.
- Memory inputs are driven only from registered state plus the latched address and data, with no combinational path from req_* to mem_*.

## Configuration
- DMEM_LSU_ERR_CHECK_EN defined:
  - All error rules above are active.
  - rsp_err is driven.
- Not defined:
  - rsp_err is tied to 0 and no request is rejected.
  - Low address bits below the access size are ignored: word accesses use word_index only, halfword accesses use addr[1].
  - Illegal funct3 behaves as a word access.
  - Out-of-range addresses are passed through to the memory unchanged.

## Test plan
- **Word store then word load**
  - Stimulus: SW addr=0x10, wdata=0xDEADBEEF; then LW addr=0x10.
  - Response: one write cycle with mem_address=0x10; LW rsp_rdata=0xDEADBEEF two cycles after acceptance; rsp_err=0.
- **Byte store read-modify-write**
  - Stimulus: preload word 4 = 0x11223344; SB addr=0x12, wdata=0xAA.
  - Response: read cycle then write cycle, mem_wdata=0x11AA3344; rsp_valid three cycles after acceptance.
- **Load extension**
  - Stimulus: word 0 = 0x0000F080.
  - Response:
    - LB addr=0 → 0xFFFFFF80
    - LBU addr=0 → 0x00000080
    - LH addr=0 → 0xFFFFF080
    - LHU addr=2 → 0x00000000
- **Errors** (macro on)
  - Stimulus: LW addr=0x6; SH addr=0x3; LW addr=0x200 with MEM_WORDS=128.
  - Response: each gives rsp_err=1 one cycle after acceptance; mem_read_en and mem_write_en stay 0 throughout.
- **Reset during WRITE**
  - Stimulus: assert reset in the WRITE cycle of SW addr=0x8, wdata=0x5.
  - Response: mem_write_en=0 in that cycle; word 2 unchanged; no rsp_valid; req_ready=1 in the cycle after reset deasserts.
- **Handshake hold-off**
  - Stimulus: hold req_valid=1 continuously with changing addresses.
  - Response: exactly one acceptance per IDLE cycle; the latched request is unaffected by input changes while busy.

Source files
------------

// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl
// Load/store sequencer between the core memory stage and a word-only data
// memory with combinational read and clocked write. Handles one byte,
// halfword or word request at a time; sub-word stores are read-modify-write.
//
// Build option: define DMEM_LSU_ERR_CHECK_EN to reject misaligned,
// out-of-range and illegal-funct3 requests with rsp_err. Without it rsp_err
// is tied low, low address bits below the access size are ignored and
// illegal funct3 codes behave as word accesses.

module dmem_lsu_ctrl #(
    parameter int MEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_RMW_RD = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    // Elaboration-time sanity check on the memory size.
    if (MEM_WORDS < 1) begin : g_bad_mem_words
        $error("dmem_lsu_ctrl: MEM_WORDS must be at least 1");
    end

    logic [2:0]  state;
    logic [2:0]  lat_funct3;   // width/sign of the accepted request
    logic [31:0] lat_addr;     // byte address of the accepted request
    logic [31:0] wbuf;         // store data, then the merged write word
    logic [31:0] rsp_rdata_q;

    logic        req_is_byte;
    logic        req_is_half;
    logic        req_is_word;
    logic        req_err;

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;
    logic [31:0] merge_word;

    // Decode the access width of the incoming request; codes 011/110/111
    // fall into the word bucket.
    always_comb begin
        req_is_byte = (req_funct3[1:0] == 2'b00);
        req_is_half = (req_funct3[1:0] == 2'b01);
        req_is_word = !req_is_byte && !req_is_half;
    end

`ifdef DMEM_LSU_ERR_CHECK_EN
    logic illegal_f3;
    logic misaligned;
    logic out_of_range;
    logic rsp_err_q;

    // Flag requests that must never reach the memory.
    always_comb begin
        illegal_f3   = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                       (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
        misaligned   = (req_is_half && req_addr[0]) ||
                       (req_is_word && (req_addr[1:0] != 2'b00));
        out_of_range = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
        req_err      = illegal_f3 || misaligned || out_of_range;
    end

    // Capture the error verdict at acceptance; it is presented with rsp_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_err_q <= 1'b0;
        end else if ((state == ST_IDLE) && req_valid) begin
            rsp_err_q <= req_err;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign req_err = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // Select and extend the addressed lane of the memory word for loads.
    // NOTE: every output of a combinational block gets a default first so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        load_byte = mem_rdata[7:0];
        case (lat_addr[1:0])
            2'b01:   load_byte = mem_rdata[15:8];
            2'b10:   load_byte = mem_rdata[23:16];
            2'b11:   load_byte = mem_rdata[31:24];
            default: load_byte = mem_rdata[7:0];
        endcase

        load_half = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        if (lat_funct3[1:0] == 2'b00) begin
            load_ext = {{24{load_byte[7] & ~lat_funct3[2]}}, load_byte};
        end else if (lat_funct3[1:0] == 2'b01) begin
            load_ext = {{16{load_half[15] & ~lat_funct3[2]}}, load_half};
        end else begin
            load_ext = mem_rdata;
        end
    end

    // Replace the addressed byte/halfword lane of the read word with store data.
    always_comb begin
        merge_word = mem_rdata;
        if (lat_funct3[1:0] == 2'b00) begin
            case (lat_addr[1:0])
                2'b01:   merge_word[15:8]  = wbuf[7:0];
                2'b10:   merge_word[23:16] = wbuf[7:0];
                2'b11:   merge_word[31:24] = wbuf[7:0];
                default: merge_word[7:0]   = wbuf[7:0];
            endcase
        end else if (lat_funct3[1:0] == 2'b01) begin
            if (lat_addr[1]) begin
                merge_word[31:16] = wbuf[15:0];
            end else begin
                merge_word[15:0] = wbuf[15:0];
            end
        end else begin
            merge_word = wbuf;
        end
    end

    // Sequencer: accept in IDLE, then walk the access path to a single RESP.
    // The load/store direction is carried by the state path, so req_we does
    // not need its own register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            lat_funct3  <= 3'b000;
            lat_addr    <= 32'h0;
            wbuf        <= 32'h0;
            rsp_rdata_q <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_funct3  <= req_funct3;
                        lat_addr    <= req_addr;
                        wbuf        <= req_wdata;
                        rsp_rdata_q <= 32'h0;
                        if (req_err) begin
                            state <= ST_RESP;
                        end else if (!req_we) begin
                            state <= ST_LOAD;
                        end else if (req_is_word) begin
                            state <= ST_WRITE;
                        end else begin
                            state <= ST_RMW_RD;
                        end
                    end
                end
                ST_LOAD: begin
                    rsp_rdata_q <= load_ext;
                    state       <= ST_RESP;
                end
                ST_RMW_RD: begin
                    wbuf  <= merge_word;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and response outputs come straight from registered state.
    assign req_ready = !reset && (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_rdata = rsp_rdata_q;

    // Memory strobes are gated by reset so a reset in WRITE aborts the store.
    assign mem_read_en  = !reset && ((state == ST_LOAD) || (state == ST_RMW_RD));
    assign mem_write_en = !reset && (state == ST_WRITE);
    assign mem_address  = {lat_addr[31:2], 2'b00};
    assign mem_wdata    = wbuf;

endmodule
